// File: rtl/delay_tap_pkg.sv
// delay_tap_pkg
// Shared types and constants for the delay-chain tap controller.
//   TAP_W             : tap code width, fixed by the delay chain
//   TAP_MAX           : last tap code of a sweep
//   delay_tap_state_e : controller state encoding
package delay_tap_pkg;

  localparam int TAP_W = 8;
  localparam logic [TAP_W-1:0] TAP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EVAL,
    LOCKED,
    FAIL
  } delay_tap_state_e;

endpackage

// File: rtl/delay_tap_window.sv
// delay_tap_window
// One evaluation window: waits SETTLE_CYC cycles after start_i, then
// accumulates i_pd over NUM_SAMPLES cycles.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   start_i          : (re)starts a window; also restarts one in progress
//   i_pd             : synchronized phase-detector bit
//   settle_done_o    : high in the last settle cycle
//   valid_o          : high in the last sample cycle
//   count_o          : number of ones in the window, valid while valid_o
//                      (includes the i_pd sampled on that same edge)
module delay_tap_window
  import delay_tap_pkg::*;
#(
  parameter int SETTLE_CYC  = 16,
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_W       = $clog2(NUM_SAMPLES) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start_i,
  input  logic             i_pd,
  output logic             settle_done_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int TMR_MAX = (SETTLE_CYC > NUM_SAMPLES) ? SETTLE_CYC : NUM_SAMPLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  logic             settling_q;
  logic             sampling_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] acc_q;

  assign settle_done_o = settling_q && (tmr_q == '0);
  assign valid_o       = sampling_q && (tmr_q == '0);
  // The final sample is folded in combinationally so the caller can act on
  // the full count on the same edge that takes the last sample.
  assign count_o       = acc_q + CNT_W'(i_pd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settling_q <= 1'b0;
      sampling_q <= 1'b0;
      tmr_q      <= '0;
      acc_q      <= '0;
    end else if (start_i) begin
      settling_q <= 1'b1;
      sampling_q <= 1'b0;
      tmr_q      <= TMR_W'(SETTLE_CYC - 1);
      acc_q      <= '0;
    end else if (settling_q) begin
      if (settle_done_o) begin
        settling_q <= 1'b0;
        sampling_q <= 1'b1;
        tmr_q      <= TMR_W'(NUM_SAMPLES - 1);
      end else begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
    end else if (sampling_q) begin
      acc_q <= count_o;
      if (valid_o) begin
        sampling_q <= 1'b0;
      end else begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl
// Generates the tap code for the IO-buffer delay chain: forwards a manual
// code in bypass, or sweeps 0..255 and locks on the first early->late
// phase-detector transition.
// Optional build macro DELAY_TAP_TRACK_EN: after lock, keep running windows
// and nudge the tap by one toward the edge (saturating).
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   c_bypass       : 1 = manual mode, o_tap follows c_tap_manual
//   c_tap_manual   : manual tap, also the fallback code on failure
//   i_cal_start    : single-cycle calibration start pulse
//   i_pd           : synchronized phase-detector bit (1 = late)
//   o_tap          : registered tap code
//   o_cal_busy     : calibration in progress
//   o_cal_done     : one-cycle pulse at lock or failure
//   o_cal_fail     : failure flag
//   o_locked       : lock flag
//
// state  | meaning
// IDLE   | not calibrating; forwards manual tap when bypassed
// SETTLE | waiting for the delay chain to settle after a tap move
// SAMPLE | accumulating phase-detector samples
// EVAL   | deciding lock / fail / next tap
// LOCKED | lock found; holds (or tracks with DELAY_TAP_TRACK_EN)
// FAIL   | sweep exhausted; manual tap applied
module delay_tap_ctrl
  import delay_tap_pkg::*;
#(
  parameter int SETTLE_CYC  = 16,
  parameter int NUM_SAMPLES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             c_bypass,
  input  logic [TAP_W-1:0] c_tap_manual,
  input  logic             i_cal_start,
  input  logic             i_pd,
  output logic [TAP_W-1:0] o_tap,
  output logic             o_cal_busy,
  output logic             o_cal_done,
  output logic             o_cal_fail,
  output logic             o_locked
);

  localparam int CNT_W = $clog2(NUM_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_SAMPLES / 2);

  delay_tap_state_e state_q;
  logic [TAP_W-1:0] tap_q;
  logic [TAP_W-1:0] tap_up_d;
  logic             busy_q, done_q, fail_q, locked_q, seen_zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             win_start, win_settle_done, win_valid;
  logic [CNT_W-1:0] win_count;
  logic             late, cal_go, eval_lock, eval_fail, eval_step;

  assign tap_up_d  = tap_q + TAP_W'(1);
  assign late      = cnt_q > HALF;
  assign cal_go    = i_cal_start &&
                     (state_q == IDLE || state_q == LOCKED || state_q == FAIL);
  // A late result only counts as lock once an early result has been seen.
  assign eval_lock = (state_q == EVAL) && late && seen_zero_q;
  assign eval_fail = (state_q == EVAL) && !eval_lock && (tap_q == TAP_MAX);
  assign eval_step = (state_q == EVAL) && !eval_lock && !eval_fail;

`ifdef DELAY_TAP_TRACK_EN
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SAMPLES);
  logic             track_win;
  logic [TAP_W-1:0] tap_dn_d;
  assign track_win = (state_q == LOCKED) && win_valid;
  assign tap_dn_d  = tap_q - TAP_W'(1);
  // Window restarts on the same edge as any tap move so settle always
  // follows the move.
  assign win_start = !c_bypass && (cal_go || eval_step || eval_lock || track_win);
`else
  assign win_start = !c_bypass && (cal_go || eval_step);
`endif

  delay_tap_window #(
    .SETTLE_CYC (SETTLE_CYC),
    .NUM_SAMPLES(NUM_SAMPLES),
    .CNT_W      (CNT_W)
  ) u_window (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .start_i      (win_start),
    .i_pd         (i_pd),
    .settle_done_o(win_settle_done),
    .valid_o      (win_valid),
    .count_o      (win_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      locked_q    <= 1'b0;
      seen_zero_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // Bypass overrides everything, including a coincident start.
      if (c_bypass) begin
        state_q  <= IDLE;
        tap_q    <= c_tap_manual;
        busy_q   <= 1'b0;
        fail_q   <= 1'b0;
        locked_q <= 1'b0;
      end else if (cal_go) begin
        state_q     <= SETTLE;
        tap_q       <= '0;
        seen_zero_q <= 1'b0;
        fail_q      <= 1'b0;
        locked_q    <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          SETTLE: if (win_settle_done) state_q <= SAMPLE;
          SAMPLE: begin
            if (win_valid) begin
              cnt_q   <= win_count;
              state_q <= EVAL;
            end
          end
          EVAL: begin
            if (!late) seen_zero_q <= 1'b1;
            if (eval_lock) begin
              locked_q <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= LOCKED;
            end else if (eval_fail) begin
              tap_q   <= c_tap_manual;
              fail_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FAIL;
            end else begin
              tap_q   <= tap_up_d;
              state_q <= SETTLE;
            end
          end
`ifdef DELAY_TAP_TRACK_EN
          LOCKED: begin
            if (track_win) begin
              if (win_count == '0 && tap_q != TAP_MAX) tap_q <= tap_up_d;
              else if (win_count == FULL && tap_q != '0) tap_q <= tap_dn_d;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign o_tap      = tap_q;
  assign o_cal_busy = busy_q;
  assign o_cal_done = done_q;
  assign o_cal_fail = fail_q;
  assign o_locked   = locked_q;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
module tb_delay_tap_ctrl;

  localparam int S    = 4;
  localparam int N    = 4;
  localparam int STEP = S + N + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       c_bypass = 1'b0;
  logic [7:0] c_tap_manual = 8'h00;
  logic       i_cal_start = 1'b0;
  logic       i_pd = 1'b0;
  logic [7:0] o_tap;
  logic       o_cal_busy, o_cal_done, o_cal_fail, o_locked;

  int checks = 0;
  int passed = 0;
  int gcyc = 0;
  // Number of ones the phase detector shows in any 4 consecutive cycles at a tap.
  int ones_tab[256];

  delay_tap_ctrl #(.SETTLE_CYC(S), .NUM_SAMPLES(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .c_bypass(c_bypass), .c_tap_manual(c_tap_manual),
    .i_cal_start(i_cal_start), .i_pd(i_pd), .o_tap(o_tap), .o_cal_busy(o_cal_busy),
    .o_cal_done(o_cal_done), .o_cal_fail(o_cal_fail), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  // Advance to the next falling edge and drive the phase detector. The
  // pattern repeats every 4 cycles, so any 4-sample window sees exactly
  // ones_tab[tap] ones regardless of alignment.
  task automatic tick();
    @(negedge i_clk);
    gcyc++;
    i_pd = (gcyc % 4) < ones_tab[o_tap];
  endtask

  function automatic void fill(int lo, int hi, int k);
    for (int t = lo; t <= hi; t++) ones_tab[t] = k;
  endfunction

  // Reference: first tap that reads late after some earlier tap read early,
  // or -1 if the sweep runs out.
  function automatic int model_lock();
    bit seen = 1'b0;
    for (int t = 0; t < 256; t++) begin
      if (ones_tab[t] > N / 2) begin
        if (seen) return t;
      end else begin
        seen = 1'b1;
      end
    end
    return -1;
  endfunction

  task automatic do_sweep(input int quiet_after, output int first_tap, output int done_n,
                          output int done_cnt, output int step_err);
    logic [7:0] prev;
    done_n = -1; done_cnt = 0; step_err = 0;
    i_cal_start = 1'b1;
    tick();
    i_cal_start = 1'b0;
    first_tap = int'(o_tap);
    prev = o_tap;
    for (int n = 0; n < 2700; n++) begin
      if (o_cal_done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (o_cal_busy && o_tap != prev && o_tap != prev + 8'd1) step_err++;
      prev = o_tap;
      if (done_n >= 0 && n >= done_n + 4) break;
      i_cal_start = (n < quiet_after) && ($urandom_range(0, 39) == 0);
      tick();
    end
    i_cal_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; c_bypass = 1'b0;
    tick(); tick();
    checks++; if (o_tap !== 8'h00) $display("FAIL reset_tap: got %h want 00", o_tap); else passed++;
    checks++; if ({o_cal_busy, o_cal_done, o_cal_fail, o_locked} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {o_cal_busy, o_cal_done, o_cal_fail, o_locked});
    else passed++;
    i_rst = 1'b0; c_bypass = 1'b1; c_tap_manual = 8'h5A;
    checks++; if (o_tap !== 8'h00) $display("FAIL manual_not_early: got %h want 00", o_tap); else passed++;
    tick();
    checks++; if (o_tap !== 8'h5A) $display("FAIL manual_5a: got %h want 5a", o_tap); else passed++;
    checks++; if ({o_cal_busy, o_cal_done, o_locked} !== 3'b000)
      $display("FAIL manual_flags: got %b want 000", {o_cal_busy, o_cal_done, o_locked});
    else passed++;
    c_tap_manual = 8'hA5;
    tick();
    checks++; if (o_tap !== 8'hA5) $display("FAIL manual_a5: got %h want a5", o_tap); else passed++;
  endtask

  task automatic test_start_with_bypass();
    c_bypass = 1'b1; c_tap_manual = 8'h3C; i_cal_start = 1'b1;
    tick();
    i_cal_start = 1'b0;
    tick();
    checks++; if (o_cal_busy !== 1'b0) $display("FAIL collide_busy: got %b want 0", o_cal_busy); else passed++;
    checks++; if (o_tap !== 8'h3C) $display("FAIL collide_tap: got %h want 3c", o_tap); else passed++;
    c_bypass = 1'b0;
    tick();
  endtask

  task automatic test_sweep(input string tag, input bit extra_starts);
    int lock, exp_n, first_tap, done_n, done_cnt, step_err;
    logic [7:0] exp_tap;
    c_tap_manual = 8'($urandom);
    lock    = model_lock();
    exp_n   = (lock >= 0) ? STEP * (lock + 1) : STEP * 256;
    exp_tap = (lock >= 0) ? 8'(lock) : c_tap_manual;
    do_sweep(extra_starts ? exp_n - 12 : 0, first_tap, done_n, done_cnt, step_err);
    checks++; if (first_tap !== 0) $display("FAIL %s first_tap: got %0d want 0", tag, first_tap); else passed++;
    checks++; if (done_n !== exp_n) $display("FAIL %s done_cycle: got %0d want %0d", tag, done_n, exp_n); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); else passed++;
    checks++; if (step_err !== 0) $display("FAIL %s tap_steps: got %0d bad steps want 0", tag, step_err); else passed++;
    checks++; if (o_locked !== (lock >= 0)) $display("FAIL %s locked: got %b want %b", tag, o_locked, lock >= 0); else passed++;
    checks++; if (o_cal_fail !== (lock < 0)) $display("FAIL %s cal_fail: got %b want %b", tag, o_cal_fail, lock < 0); else passed++;
    checks++; if (o_cal_busy !== 1'b0) $display("FAIL %s busy_end: got %b want 0", tag, o_cal_busy); else passed++;
    checks++; if (o_tap !== exp_tap) $display("FAIL %s final_tap: got %0d want %0d", tag, o_tap, exp_tap); else passed++;
  endtask

  task automatic test_lock_hold();
    fill(0, 255, 0);
    repeat (60) tick();
`ifdef DELAY_TAP_TRACK_EN
    checks++; if (!(o_tap > 8'd37)) $display("FAIL track_tap: got %0d want >37", o_tap); else passed++;
`else
    checks++; if (o_tap !== 8'd37) $display("FAIL hold_tap: got %0d want 37", o_tap); else passed++;
`endif
    checks++; if (o_locked !== 1'b1) $display("FAIL hold_locked: got %b want 1", o_locked); else passed++;
  endtask

  task automatic test_bypass_from_locked();
    logic [7:0] m;
    m = 8'($urandom);
    c_bypass = 1'b1; c_tap_manual = m;
    tick();
    checks++; if (o_locked !== 1'b0) $display("FAIL unlock_locked: got %b want 0", o_locked); else passed++;
    checks++; if (o_tap !== m) $display("FAIL unlock_tap: got %h want %h", o_tap, m); else passed++;
    c_bypass = 1'b0; c_tap_manual = ~m;
    tick(); tick();
    checks++; if (o_tap !== m) $display("FAIL idle_hold: got %h want %h", o_tap, m); else passed++;
  endtask

  task automatic test_fail_restart();
    fill(0, 255, 4);
    test_sweep("stuck_high", 1'b0);
    i_cal_start = 1'b1;
    tick();
    i_cal_start = 1'b0;
    checks++; if (o_cal_fail !== 1'b0) $display("FAIL restart_fail_clr: got %b want 0", o_cal_fail); else passed++;
    checks++; if (o_cal_busy !== 1'b1) $display("FAIL restart_busy: got %b want 1", o_cal_busy); else passed++;
    c_bypass = 1'b1;
    tick();
    c_bypass = 1'b0;
    tick();
  endtask

  task automatic wait_tap10(input string tag);
    int k = 0;
    while (o_tap !== 8'd10 && k < 400) begin tick(); k++; end
    checks++; if (o_tap !== 8'd10) $display("FAIL %s reach_tap10: got %0d want 10", tag, o_tap); else passed++;
    repeat ($urandom_range(0, STEP - 1)) tick();
  endtask

  task automatic test_abort_bypass();
    logic [7:0] m;
    int dones = 0;
    fill(0, 255, 0);
    i_cal_start = 1'b1; tick(); i_cal_start = 1'b0;
    wait_tap10("abort_byp");
    m = 8'($urandom);
    c_bypass = 1'b1; c_tap_manual = m;
    tick();
    checks++; if (o_cal_busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", o_cal_busy); else passed++;
    checks++; if (o_tap !== m) $display("FAIL abort_tap: got %h want %h", o_tap, m); else passed++;
    for (int i = 0; i < 300; i++) begin
      if (o_cal_done) dones++;
      if (i == 150) c_tap_manual = ~m;
      tick();
    end
    checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", dones); else passed++;
    checks++; if (o_tap !== ~m) $display("FAIL abort_follow: got %h want %h", o_tap, ~m); else passed++;
    c_bypass = 1'b0;
    tick();
  endtask

  task automatic test_abort_reset();
    int dones = 0;
    fill(0, 255, 0);
    i_cal_start = 1'b1; tick(); i_cal_start = 1'b0;
    wait_tap10("abort_rst");
    i_rst = 1'b1;
    tick();
    checks++; if ({o_tap, o_cal_busy, o_cal_done, o_cal_fail, o_locked} !== 12'h000)
      $display("FAIL rst_mid_cal: got tap=%h flags=%b want all 0", o_tap,
               {o_cal_busy, o_cal_done, o_cal_fail, o_locked});
    else passed++;
    i_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_cal_done || o_cal_busy) dones++;
      tick();
    end
    checks++; if (dones !== 0) $display("FAIL rst_quiet: got %0d active cycles want 0", dones); else passed++;
  endtask

  initial begin
    int a, t_lock;
    fill(0, 255, 0);
    test_reset();
    test_start_with_bypass();

    fill(0, 36, 0); fill(37, 255, 4);
    test_sweep("clean37", 1'b0);
    test_lock_hold();
    test_bypass_from_locked();

    fill(0, 19, 0); fill(20, 255, 3);
    test_sweep("noisy20", 1'b1);

    fill(0, 9, 0); fill(10, 29, 2); fill(30, 255, 4);
    test_sweep("half30", 1'b0);

    for (int it = 0; it < 3; it++) begin
      a = $urandom_range(0, 30);
      t_lock = $urandom_range(a + 1, 220);
      for (int t = 0; t < 256; t++)
        ones_tab[t] = (t < a) ? $urandom_range(3, 4) :
                      (t < t_lock) ? $urandom_range(0, 2) : $urandom_range(3, 4);
      test_sweep("random", 1'b1);
    end

    test_fail_restart();
    test_abort_bypass();
    test_abort_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
Calibration and control stage that generates the 8-bit tap code driven into the AIB IO buffer delay chain's c_tap input.
- Manual mode: forwards a register-programmed tap.
- Calibration mode: sweeps tap codes 0..255, samples a synchronized phase-detector bit after each move, and locks on the first 0->1 transition.
- Tap code is plain binary: bits [7:4] select the coarse delay stage, [3:2] the medium stage, [1:0] the fine stage. Incrementing the code monotonically increases delay.

Parameters:
TAP_W, 8, tap code width; fixed by the delay chain.
SETTLE_CYC, 16, wait cycles after any tap change before sampling; must be >=1.
NUM_SAMPLES, 8, phase-detector samples per evaluation window; power of two, >=2.

Ports:
i_clk  input  1  block clock
i_rst  input  1  synchronous, active-high reset
c_bypass  input  1  1 = manual mode; o_tap follows c_tap_manual
c_tap_manual  input  8  manual tap code; also the fallback code on calibration failure
i_cal_start  input  1  single-cycle pulse that starts calibration
i_pd  input  1  phase-detector output, already synchronized to i_clk; 1 = delayed edge late
o_tap  output  8  registered tap code to the delay chain's c_tap
o_cal_busy  output  1  high while calibration is in progress
o_cal_done  output  1  one-cycle pulse when calibration ends (lock or fail)
o_cal_fail  output  1  level; set on failure, cleared by the next i_cal_start or reset
o_locked  output  1  level; set on lock, cleared by i_cal_start, c_bypass, or reset

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: o_tap=0, o_cal_busy=0, o_cal_done=0, o_cal_fail=0, o_locked=0; state IDLE; all counters 0.
- All outputs are registered. o_tap changes at most once per evaluation step, by +1 only during a sweep (glitch-free on the chain's mux selects).
- States: IDLE, SETTLE, SAMPLE, EVAL, LOCKED, FAIL.
- IDLE:
  - With c_bypass=1: o_tap <= c_tap_manual each cycle (1-cycle latency).
  - With c_bypass=0: o_tap holds.
  - i_cal_start with c_bypass=0 -> o_tap<=0, seen_zero<=0, flags cleared, o_cal_busy<=1, go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE:
  - Accumulate i_pd over exactly NUM_SAMPLES cycles into a counter of width log2(NUM_SAMPLES)+1.
  - Then go to EVAL.
- EVAL (1 cycle): late = (count > NUM_SAMPLES/2). Transitions, first match wins:
  - late=1 and seen_zero=1: o_locked<=1, o_cal_done pulse, busy<=0, go to LOCKED; o_tap holds.
  - late=0: seen_zero<=1.
  - o_tap==255 and not locked: go to FAIL; o_tap<=c_tap_manual, o_cal_fail<=1, o_cal_done pulse, busy<=0.
  - Otherwise: o_tap<=o_tap+1, go to SETTLE.
- Sweep timing: each tap costs SETTLE_CYC+NUM_SAMPLES+1 cycles.
- A late=1 at tap 0 is never a lock. seen_zero must be set first.
- LOCKED and FAIL:
  - Hold outputs.
  - i_cal_start restarts calibration as from IDLE.
  - c_bypass=1 -> go to IDLE, clear o_locked/o_cal_fail.
- c_bypass=1 during SETTLE/SAMPLE/EVAL: abort to IDLE next cycle, busy<=0, no o_cal_done pulse; manual forwarding resumes.
- i_cal_start while busy: ignored.
- Simultaneous i_cal_start and c_bypass=1: bypass wins, start is ignored.
- i_rst mid-calibration: immediate return to reset values; no done pulse.

Optional Feature:
DELAY_TAP_TRACK_EN
- Defined: LOCKED continuously repeats SETTLE/SAMPLE windows (o_locked stays 1).
  - Window count==0 -> o_tap+1, saturating at 255.
  - Window count==NUM_SAMPLES -> o_tap-1, saturating at 0.
  - Otherwise hold.
  - Each move re-enters SETTLE.
  - Bypass/start/reset rules are unchanged.
- Undefined: LOCKED is static; i_pd is ignored after lock.

Decomposition:
- Package delay_tap_pkg:
  - state enum delay_tap_state_e (IDLE, SETTLE, SAMPLE, EVAL, LOCKED, FAIL)
  - TAP_W=8, TAP_MAX=8'hFF
- Sub-module delay_tap_window: settle counter plus sample accumulator.
  - Inputs: start, i_pd.
  - Outputs: valid pulse, count.
  - Reused by both sweep and tracking.

Test Plan:
- Reset, then c_bypass=1, c_tap_manual=8'h5A -> o_tap=8'h5A one cycle later; busy, done, locked all 0.
- SETTLE_CYC=4, NUM_SAMPLES=4, c_bypass=0, model i_pd=(tap>=37), pulse i_cal_start -> o_tap steps 0..37; single o_cal_done pulse at 38*9 cycles (+/-1) after start; o_locked=1, o_tap=37.
- i_pd stuck 1 -> sweep reaches 255, o_cal_fail=1, o_tap=c_tap_manual, one done pulse, o_locked=0.
- Start calibration, assert c_bypass at tap 10 -> IDLE next cycle, busy=0, no done pulse, o_tap follows manual. Repeat with i_rst at tap 10 -> all outputs 0.
- i_pd noisy (3 of 4 samples =1 at tap>=20, all 0 below) -> lock at 20. Extra i_cal_start pulses while busy have no effect.
- With DELAY_TAP_TRACK_EN, locked at 37, force i_pd=0 -> o_tap goes 38, 39, ... one step per 8 cycles, saturating at 255. Without the macro, o_tap stays 37.
